// File: rtl/arb_weighted_rr_if.sv
// Request/grant/config bundle for arb_weighted_rr. The lock signal exists only
// when ARB_WRR_LOCK_EN is defined.
interface arb_weighted_rr_if #(
  parameter int REQ_NUM  = 4,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = $clog2(REQ_NUM)
);
  logic [REQ_NUM-1:0]  req;
  logic [REQ_NUM-1:0]  grant;
  logic                grant_vld;
  logic [IDX_W-1:0]    grant_id;
  logic [WEIGHT_W-1:0] credit;
  logic                cfg_we;
  logic [IDX_W-1:0]    cfg_idx;
  logic [WEIGHT_W-1:0] cfg_weight;
`ifdef ARB_WRR_LOCK_EN
  logic                lock;
`endif

  modport master (
    output req, cfg_we, cfg_idx, cfg_weight,
`ifdef ARB_WRR_LOCK_EN
    output lock,
`endif
    input  grant, grant_vld, grant_id, credit
  );

  modport slave (
    input  req, cfg_we, cfg_idx, cfg_weight,
`ifdef ARB_WRR_LOCK_EN
    input  lock,
`endif
    output grant, grant_vld, grant_id, credit
  );
endinterface

// File: rtl/arb_weighted_rr.sv
// Weighted round-robin arbiter: each owner holds the grant for up to its weight in
// cycles, then ownership rotates. Define ARB_WRR_LOCK_EN to let lock extend a tenure.
module arb_weighted_rr #(
  parameter int REQ_NUM  = 4,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = $clog2(REQ_NUM)
) (
  input logic               clk,
  input logic               rst,
  arb_weighted_rr_if.slave  bus
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e              r_state, w_state_nxt;
  logic [REQ_NUM-1:0]  r_grant, w_grant_nxt;
  logic [IDX_W-1:0]    r_grant_id, w_id_nxt;
  logic [WEIGHT_W-1:0] r_credit, w_credit_nxt;
  logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
  logic [WEIGHT_W-1:0] r_weight [REQ_NUM];

  logic                w_found;
  logic [IDX_W-1:0]    w_sel;
  logic [WEIGHT_W-1:0] w_load;
  logic                w_quota_done;
  logic                w_release;
  logic [IDX_W-1:0]    w_owner_next;

  // Scan ptr, ptr+1, ... with wrap; iterating downwards lets the closest hit win.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      if (bus.req[(int'(r_ptr) + k) % REQ_NUM]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'((int'(r_ptr) + k) % REQ_NUM);
      end
    end
  end

  assign w_load = (r_weight[w_sel] == '0) ? WEIGHT_W'(1) : r_weight[w_sel];

`ifdef ARB_WRR_LOCK_EN
  assign w_quota_done = (r_credit == WEIGHT_W'(1)) && !bus.lock;
`else
  assign w_quota_done = (r_credit == WEIGHT_W'(1));
`endif

  assign w_release    = !bus.req[r_grant_id] || w_quota_done;
  assign w_owner_next = (r_grant_id == IDX_W'(REQ_NUM - 1)) ? '0 : r_grant_id + IDX_W'(1);

  always_comb begin
    // NOTE: every signal gets its hold value first so no branch can infer a latch.
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_id_nxt     = r_grant_id;
    w_credit_nxt = r_credit;
    w_ptr_nxt    = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt        = '0;
          w_grant_nxt[w_sel] = 1'b1;
          w_id_nxt           = w_sel;
          w_credit_nxt       = w_load;
          w_state_nxt        = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_release) begin
          w_grant_nxt  = '0;
          w_id_nxt     = '0;
          w_credit_nxt = '0;
          w_ptr_nxt    = w_owner_next;
          w_state_nxt  = S_IDLE;
        end else if (r_credit > WEIGHT_W'(1)) begin
          // A locked tenure parks at credit 1 instead of decrementing further.
          w_credit_nxt = r_credit - WEIGHT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_credit   <= '0;
      r_ptr      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_id_nxt;
      r_credit   <= w_credit_nxt;
      r_ptr      <= w_ptr_nxt;
    end
  end

  // Weights are software-visible config, so unlike a data RAM they need a known reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REQ_NUM; i++) r_weight[i] <= WEIGHT_W'(1);
    end else if (bus.cfg_we && (int'(bus.cfg_idx) < REQ_NUM)) begin
      r_weight[bus.cfg_idx] <= bus.cfg_weight;
    end
  end

  assign bus.grant     = r_grant;
  assign bus.grant_vld = |r_grant;
  assign bus.grant_id  = r_grant_id;
  assign bus.credit    = r_credit;

endmodule

// File: tb/tb_arb_weighted_rr.sv
// Self-checking bench for arb_weighted_rr: directed scenarios plus randomized traffic
// compared each cycle against a tenure-level reference model.
module tb_arb_weighted_rr;
  localparam int N  = 4;
  localparam int WW = 4;
  localparam int IW = 3;  // one spare bit so cfg_idx = N is representable

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_weighted_rr_if #(.REQ_NUM(N), .WEIGHT_W(WW), .IDX_W(IW)) bif ();

  arb_weighted_rr #(.REQ_NUM(N), .WEIGHT_W(WW), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner index (-1 = nobody), cycles left, rotation start, weights.
  int m_owner, m_left, m_ptr;
  int m_w [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit lock_on();
`ifdef ARB_WRR_LOCK_EN
    return bif.lock;
`else
    return 1'b0;
`endif
  endfunction

  // One clock edge: advance the model using the inputs present before the edge,
  // then compare every output 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_left = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_w[i] = 1;
    end else begin
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && bif.req[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            m_left  = (m_w[m_owner] == 0) ? 1 : m_w[m_owner];
          end
        end
      end else if (!bif.req[m_owner] || (m_left == 1 && !lock_on())) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_left  = 0;
      end else if (m_left > 1) begin
        m_left--;
      end
      if (bif.cfg_we && int'(bif.cfg_idx) < N) m_w[bif.cfg_idx] = int'(bif.cfg_weight);
    end
    #1;
    check("grant",     32'(bif.grant),     (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check("grant_vld", 32'(bif.grant_vld), 32'(m_owner >= 0));
    check("grant_id",  32'(bif.grant_id),  (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("credit",    32'(bif.credit),    32'(m_left));
    check("onehot0",   32'($onehot0(bif.grant)), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input int w);
    bif.cfg_we = 1'b1; bif.cfg_idx = IW'(idx); bif.cfg_weight = WW'(w);
    tick();
    bif.cfg_we = 1'b0;
  endtask

  logic [3:0] t1_exp [10];

  initial begin
    rst = 1'b1;
    bif.req = '0; bif.cfg_we = 1'b0; bif.cfg_idx = '0; bif.cfg_weight = '0;
`ifdef ARB_WRR_LOCK_EN
    bif.lock = 1'b0;
`endif
    m_owner = -1; m_left = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_w[i] = 1;

    // Reset defaults
    do_reset();
    check("rst_grant",  32'(bif.grant), 32'd0);
    check("rst_credit", 32'(bif.credit), 32'd0);

    // 1: plain round robin with all weights 1
    t1_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
               4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    bif.req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t1_seq%0d", i), 32'(bif.grant), 32'(t1_exp[i]));
    end

    // 2: weight quota, credit counts down 3,2,1, one idle cycle, regained
    bif.req = '0;
    do_reset();
    cfg_write(2, 3);
    bif.req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_grant",  32'(bif.grant),  32'h4);
      check("t2_credit", 32'(bif.credit), 32'(3 - i));
    end
    tick();
    check("t2_idle", 32'(bif.grant), 32'h0);
    tick();
    check("t2_regain", 32'(bif.grant), 32'h4);

    // 3: early release, then requester 3 wins from ptr=2
    bif.req = '0;
    do_reset();
    cfg_write(1, 5);
    bif.req = 4'b1010;
    tick();
    check("t3_own1", 32'(bif.grant), 32'h2);
    tick();
    check("t3_cred", 32'(bif.credit), 32'd4);
    bif.req = 4'b1000;
    tick();
    check("t3_drop", 32'(bif.grant), 32'h0);
    tick();
    check("t3_next", 32'(bif.grant_id), 32'd3);

    // 4: config during tenure leaves current credit alone; out-of-range index ignored
    bif.req = '0;
    do_reset();
    cfg_write(0, 4);
    bif.req = 4'b0001;
    tick();
    tick();
    check("t4_c3", 32'(bif.credit), 32'd3);
    cfg_write(0, 1);
    check("t4_c2", 32'(bif.credit), 32'd2);
    cfg_write(N, 9);
    check("t4_c1", 32'(bif.credit), 32'd1);
    tick();
    check("t4_idle", 32'(bif.grant), 32'h0);
    tick();
    check("t4_w1", 32'(bif.credit), 32'd1);
    tick();
    check("t4_idle2", 32'(bif.grant), 32'h0);

    // 5: reset mid-tenure, defaults restored, weight 0 acts as 1
    bif.req = '0;
    do_reset();
    cfg_write(0, 3);
    bif.req = 4'b0001;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_drop", 32'(bif.grant), 32'h0);
    bif.req = 4'b0011;
    tick();
    check("t5_ptr0", 32'(bif.grant_id), 32'd0);
    check("t5_w1",   32'(bif.credit),   32'd1);
    bif.req = '0;
    tick();
    cfg_write(2, 0);
    bif.req = 4'b0100;
    tick();
    check("t5_w0", 32'(bif.credit), 32'd1);
    tick();
    check("t5_w0_end", 32'(bif.grant), 32'h0);

`ifdef ARB_WRR_LOCK_EN
    // 6: lock stretches a weight-2 tenure to 6 cycles
    bif.req = '0;
    do_reset();
    cfg_write(0, 2);
    bif.req = 4'b0001;
    bif.lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t6_hold", 32'(bif.grant), 32'h1);
    end
    bif.lock = 1'b0;
    tick();
    check("t6_drop", 32'(bif.grant), 32'h0);
`endif

    // Randomized traffic, config writes (including out-of-range indices) and rare resets
    bif.req = '0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) bif.req = N'($urandom_range(0, 15));
      bif.cfg_we     = ($urandom_range(0, 5) == 0);
      bif.cfg_idx    = IW'($urandom_range(0, 7));
      bif.cfg_weight = WW'($urandom_range(0, 15));
      rst            = ($urandom_range(0, 99) == 0);
`ifdef ARB_WRR_LOCK_EN
      bif.lock       = ($urandom_range(0, 2) == 0);
`endif
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
